// File: rtl/regfile_wb_pkg.sv
// Shared types and default constants for the register-file write-back controller.
package regfile_wb_pkg;

   localparam int AWL_DEF          = 5;
   localparam int DWL_DEF          = 32;
   localparam int FIFO_DEPTH_DEF   = 4;
   localparam int STARVE_LIMIT_DEF = 3;

   typedef struct packed {
      logic [AWL_DEF-1:0] addr;
      logic [DWL_DEF-1:0] data;
   } wb_req_t;

   typedef enum logic {
      NORMAL = 1'b0,
      DRAIN  = 1'b1
   } arb_state_e;

endpackage

// File: rtl/regfile_writeback_fifo.sv
// wb_fifo: synchronous FIFO of write-back requests; registered storage, no read bypass,
// so a pushed entry is visible at the head only from the following cycle.
module wb_fifo
   import regfile_wb_pkg::*;
#(
   parameter int  DEPTH = FIFO_DEPTH_DEF,
   parameter type T     = wb_req_t
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  T                           push_data,
   input  logic                       pop,
   output T                           pop_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   T               mem_q [DEPTH];
   T               mem_d [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic           do_push, do_pop;

   assign full     = (count_q == CW'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_push  = push && !full;
      do_pop   = pop && !empty;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop)
         rd_ptr_d = rd_ptr_q + PW'(1);
      // Pointers wrap naturally because DEPTH is a power of two.
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter: ALU results have priority, load results queue in a FIFO
// with a starvation limit. Optional macro REGFILE_WB_ZERO_REG_EN suppresses writes to address 0.
module regfile_writeback
   import regfile_wb_pkg::*;
#(
   parameter int AWL          = AWL_DEF,
   parameter int DWL          = DWL_DEF,
   parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          alu_valid,
   output logic                          alu_ready,
   input  logic [AWL-1:0]                alu_addr,
   input  logic [DWL-1:0]                alu_data,
   input  logic                          ld_valid,
   output logic                          ld_ready,
   input  logic [AWL-1:0]                ld_addr,
   input  logic [DWL-1:0]                ld_data,
   output logic                          wen,
   output logic [AWL-1:0]                WA,
   output logic [DWL-1:0]                WD,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic [AWL-1:0] addr;
      logic [DWL-1:0] data;
   } req_t;

   arb_state_e     state_q, state_d;
   logic [SW-1:0]  starve_cnt_q, starve_cnt_d;
   logic           win_vld_q, win_vld_d;
   req_t           win_q, win_d;
   logic           wen_q, wen_d;
   logic [AWL-1:0] wa_q, wa_d;
   logic [DWL-1:0] wd_q, wd_d;

   logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
   req_t           fifo_in, fifo_head;
   logic           wr_en;

   assign fifo_in   = '{addr: ld_addr, data: ld_data};
   assign ld_ready  = !fifo_full;
   assign fifo_push = ld_valid && ld_ready;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH),
      .T     (req_t)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // Arbitration and starvation accounting.
   always_comb begin
      alu_ready    = (state_q == NORMAL);
      fifo_pop     = 1'b0;
      win_vld_d    = 1'b0;
      win_d        = '{addr: alu_addr, data: alu_data};
      starve_cnt_d = '0;
      state_d      = NORMAL;
      case (state_q)
         NORMAL: begin
            if (alu_valid) begin
               win_vld_d = 1'b1;
               if (!fifo_empty)
                  starve_cnt_d = starve_cnt_q + SW'(1);
            end else if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               win_vld_d = 1'b1;
               win_d     = fifo_head;
            end
            if (starve_cnt_d == SW'(STARVE_LIMIT))
               state_d = DRAIN;
         end
         DRAIN: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               win_vld_d = 1'b1;
               win_d     = fifo_head;
            end
         end
         default: state_d = NORMAL;
      endcase
   end

   // Output stage: the captured winner drives the write port one edge later.
   always_comb begin
`ifdef REGFILE_WB_ZERO_REG_EN
      wr_en = win_vld_q && (win_q.addr != '0);
`else
      wr_en = win_vld_q;
`endif
      wen_d = wr_en;
      wa_d  = wa_q;
      wd_d  = wd_q;
      if (wr_en) begin
         wa_d = win_q.addr;
         wd_d = win_q.data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= NORMAL;
         starve_cnt_q <= '0;
         win_vld_q    <= 1'b0;
         win_q        <= '0;
         wen_q        <= 1'b0;
         wa_q         <= '0;
         wd_q         <= '0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         win_vld_q    <= win_vld_d;
         win_q        <= win_d;
         wen_q        <= wen_d;
         wa_q         <= wa_d;
         wd_q         <= wd_d;
      end
   end

   assign wen = wen_q;
   assign WA  = wa_q;
   assign WD  = wd_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: queue-based reference model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_addr;
   logic [31:0] alu_data;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_addr;
   logic [31:0] ld_data;
   logic        wen;
   logic [4:0]  WA;
   logic [31:0] WD;
   logic [2:0]  fifo_count;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   regfile_writeback dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_addr   (alu_addr),
      .alu_data   (alu_data),
      .ld_valid   (ld_valid),
      .ld_ready   (ld_ready),
      .ld_addr    (ld_addr),
      .ld_data    (ld_data),
      .wen        (wen),
      .WA         (WA),
      .WD         (WD),
      .fifo_count (fifo_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp)
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else
         n_pass++;
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        q[$];
   ent_t        mid;
   bit          mid_v, m_ok, drain;
   int          starve;
   logic        wen_e;
   logic [4:0]  wa_e;
   logic [31:0] wd_e;

   initial begin
      m_ok = 0; drain = 0; starve = 0; mid_v = 0;
      wen_e = 0; wa_e = 0; wd_e = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         m_ok = 1; drain = 0; starve = 0; mid_v = 0;
         wen_e = 0; wa_e = 0; wd_e = 0;
      end else if (m_ok) begin
         bit   ne, push_ok, was_drain, wr;
         ent_t nxt;
         ne      = (q.size() != 0);
         push_ok = ld_valid && (q.size() < 4);
`ifdef REGFILE_WB_ZERO_REG_EN
         wr = mid_v && (mid.a != 0);
`else
         wr = mid_v;
`endif
         wen_e = wr;
         if (wr) begin wa_e = mid.a; wd_e = mid.d; end
         was_drain = drain;
         drain     = 0;
         if (!was_drain && alu_valid) begin
            nxt.a = alu_addr; nxt.d = alu_data;
            mid = nxt; mid_v = 1;
            starve = ne ? starve + 1 : 0;
         end else if (ne) begin
            mid = q.pop_front(); mid_v = 1;
            starve = 0;
         end else begin
            mid_v = 0; starve = 0;
         end
         if (!was_drain && starve == 3) drain = 1;
         if (push_ok) begin
            nxt.a = ld_addr; nxt.d = ld_data;
            q.push_back(nxt);
         end
      end
   end

   always @(negedge clk) begin
      if (m_ok && !rst) begin
         chk("m_alu_ready", alu_ready, !drain);
         chk("m_ld_ready", ld_ready, q.size() < 4);
         chk("m_fifo_count", fifo_count, q.size());
         chk("m_wen", wen, wen_e);
         chk("m_WA", WA, wa_e);
         chk("m_WD", WD, wd_e);
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1; alu_valid = 0; alu_addr = 0; alu_data = 0;
      ld_valid = 0; ld_addr = 0; ld_data = 0;
      tick(); tick();
      rst = 0;
      chk("rst_wen", wen, 0);
      chk("rst_WA", WA, 0);
      chk("rst_WD", WD, 0);
      chk("rst_alu_ready", alu_ready, 1);
      chk("rst_ld_ready", ld_ready, 1);
      chk("rst_count", fifo_count, 0);
      tick();

      // single ALU write
      alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF;
      tick();
      alu_valid = 0;
      chk("alu_wen_n", wen, 0);
      tick();
      chk("alu_wen_n1", wen, 1);
      chk("alu_WA", WA, 5);
      chk("alu_WD", WD, 32'hDEADBEEF);
      tick();
      chk("alu_wen_after", wen, 0);
      chk("alu_WA_hold", WA, 5);

      // load into idle block
      ld_valid = 1; ld_addr = 7; ld_data = 32'h12345678;
      tick();
      ld_valid = 0;
      chk("ld_count_n", fifo_count, 1);
      chk("ld_wen_n", wen, 0);
      tick();
      chk("ld_count_n1", fifo_count, 0);
      chk("ld_wen_n1", wen, 0);
      tick();
      chk("ld_wen_n2", wen, 1);
      chk("ld_WA", WA, 7);
      chk("ld_WD", WD, 32'h12345678);
      tick(); tick();

      // FIFO fill while ALU streams
      alu_valid = 1; ld_valid = 1;
      for (int i = 0; i < 4; i++) begin
         alu_addr = 5'(20 + i); alu_data = 32'hA000 + i;
         ld_addr  = 5'(10 + i); ld_data  = 32'hB000 + i;
         tick();
      end
      chk("fill_count4", fifo_count, 4);
      chk("fill_ld_ready", ld_ready, 0);
      chk("fill_drain", alu_ready, 0);
      ld_addr = 14; ld_data = 32'hB004;
      tick();
      chk("fill_pop_count", fifo_count, 3);
      chk("fill_ld_ready_again", ld_ready, 1);
      chk("fill_alu_ready_again", alu_ready, 1);
      tick();
      chk("fill_5th_in", fifo_count, 4);
      alu_valid = 0; ld_valid = 0;
      for (int i = 0; i < 10; i++) tick();
      chk("fill_drained", fifo_count, 0);

      // starvation
      ld_valid = 1; ld_addr = 3; ld_data = 32'hAAAA;
      tick();
      ld_valid = 0;
      alu_valid = 1; alu_addr = 9; alu_data = 32'h9999;
      tick();
      chk("starve_e1", alu_ready, 1);
      tick();
      chk("starve_e2", alu_ready, 1);
      tick();
      chk("starve_drain", alu_ready, 0);
      chk("starve_count", fifo_count, 1);
      tick();
      chk("starve_back", alu_ready, 1);
      chk("starve_popped", fifo_count, 0);
      tick();
      chk("starve_WA", WA, 3);
      chk("starve_WD", WD, 32'hAAAA);
      alu_valid = 0;
      tick(); tick(); tick();

      // zero register
      alu_valid = 1; alu_addr = 0; alu_data = 32'h55;
      chk("zero_handshake", alu_ready, 1);
      tick();
      alu_valid = 0;
      tick();
`ifdef REGFILE_WB_ZERO_REG_EN
      chk("zero_wen", wen, 0);
`else
      chk("zero_wen", wen, 1);
      chk("zero_WA", WA, 0);
`endif
      tick();

      // mid-stream reset with three queued loads
      alu_valid = 1; ld_valid = 1;
      for (int i = 0; i < 3; i++) begin
         alu_addr = 5'(25 + i); alu_data = 32'hC000 + i;
         ld_addr  = 5'(15 + i); ld_data  = 32'hD000 + i;
         tick();
      end
      chk("mrst_count3", fifo_count, 3);
      rst = 1; ld_valid = 0;
      tick();
      rst = 0; alu_valid = 0;
      chk("mrst_count", fifo_count, 0);
      chk("mrst_wen", wen, 0);
      chk("mrst_WA", WA, 0);
      chk("mrst_WD", WD, 0);
      chk("mrst_ld_ready", ld_ready, 1);
      chk("mrst_alu_ready", alu_ready, 1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mrst_no_write", wen, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
